// File: rtl/gate_test_sequencer.sv
// Self-checking stimulus sequencer for a 2-input gate: walks {a,b}=00..11,
// waits a settle window, compares gate_y against TRUTH and reports the result.
module gate_test_sequencer #(
  parameter logic [3:0] TRUTH         = 4'b1000,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_idx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic [1:0] idx_r;
  logic [3:0] settle_cnt_r;
  logic       gate_a_r;
  logic       gate_b_r;
  logic       busy_r;
  logic       done_r;
  logic       pass_r;
  logic [2:0] err_count_r;
  logic       fail_valid_r;
  logic [1:0] first_fail_idx_r;
  logic       mismatch_s;
  logic [2:0] err_next_s;

  assign mismatch_s = (state_r == SAMPLE) && (gate_y != TRUTH[idx_r]);
  // Includes the current sample, so pass can reflect a last-vector mismatch in the done cycle.
  assign err_next_s = err_count_r + {2'b00, mismatch_s};

  assign gate_a         = gate_a_r;
  assign gate_b         = gate_b_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign fail_valid     = fail_valid_r;
  assign first_fail_idx = first_fail_idx_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = APPLY;
        end else begin
          state_s = IDLE;
        end
      end
      APPLY:  state_s = SETTLE;
      SETTLE: begin
        if (settle_cnt_r == 4'd0) begin
          state_s = SAMPLE;
        end else begin
          state_s = SETTLE;
        end
      end
      SAMPLE: begin
        if (idx_r == 2'd3) begin
          state_s = DONE;
        end else begin
          state_s = APPLY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Vector drive, settle timing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r            <= 2'd0;
      settle_cnt_r     <= 4'd0;
      gate_a_r         <= 1'b0;
      gate_b_r         <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_count_r      <= 3'd0;
      fail_valid_r     <= 1'b0;
      first_fail_idx_r <= 2'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r           <= 1'b1;
            idx_r            <= 2'd0;
            pass_r           <= 1'b0;
            err_count_r      <= 3'd0;
            fail_valid_r     <= 1'b0;
            first_fail_idx_r <= 2'd0;
          end
        end
        APPLY: begin
          gate_a_r     <= idx_r[1];
          gate_b_r     <= idx_r[0];
          settle_cnt_r <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt_r != 4'd0) begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        SAMPLE: begin
          err_count_r <= err_next_s;
          if (mismatch_s && !fail_valid_r) begin
            fail_valid_r     <= 1'b1;
            first_fail_idx_r <= idx_r;
          end
          if (idx_r == 2'd3) begin
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            pass_r   <= (err_next_s == 3'd0);
            gate_a_r <= 1'b0;
            gate_b_r <= 1'b0;
            idx_r    <= 2'd0;
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: three instances cover the AND truth
// table with selectable gate behaviour, and an XOR gate at SETTLE_CYCLES=1.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   gate_sel = 0;  // dut0 gate: 0=AND, 1=tied 0, 2=NAND

  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic       y0, y1, y2;
  logic       a0, b0, busy0, done0, pass0, fv0;
  logic       a1, b1, busy1, done1, pass1, fv1;
  logic       a2, b2, busy2, done2, pass2, fv2;
  logic [2:0] err0, err1, err2;
  logic [1:0] ffi0, ffi1, ffi2;

  always #5 clk = ~clk;

  always_comb begin
    case (gate_sel)
      1:       y0 = 1'b0;
      2:       y0 = ~(a0 & b0);
      default: y0 = a0 & b0;
    endcase
  end
  assign y1 = a1 ^ b1;
  assign y2 = a2 ^ b2;

  gate_test_sequencer #(.TRUTH(4'b1000), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_y(y0), .gate_a(a0), .gate_b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .first_fail_idx(ffi0));

  gate_test_sequencer #(.TRUTH(4'b0110), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_y(y1), .gate_a(a1), .gate_b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_idx(ffi1));

  gate_test_sequencer #(.TRUTH(4'b1000), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_y(y2), .gate_a(a2), .gate_b(b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_idx(ffi2));

  function automatic logic sel_done(input int which);
    case (which)
      1:       return done1;
      2:       return done2;
      default: return done0;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      1:       start1 = v;
      2:       start2 = v;
      default: start0 = v;
    endcase
  endtask

  // Pulse start on one instance; done_cyc = edges after acceptance until done (-1 on timeout).
  task automatic run_dut(input int which, output int done_cyc);
    repeat (2) begin @(posedge clk); #1; end
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (sel_done(which)) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, ffi0} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 0000000000",
               {a0, b0, busy0, done0, pass0, err0, fv0, ffi0});
    end
    rst = 1'b0;
  endtask

  task automatic test_and_pass();
    logic [1:0] v;
    gate_sel = 0;
    repeat (2) begin @(posedge clk); #1; end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      v = 2'((c - 1) / 4);
      tests_run++;
      if ({a0, b0, busy0, done0} !== {v, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL and_vector c=%0d: got a,b,busy,done=%b expected %b",
                 c, {a0, b0, busy0, done0}, {v, 1'b1, 1'b0});
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if ({done0, busy0, pass0, err0, fv0, a0, b0} !== {1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL and_done: got done,busy,pass,err,fv,a,b=%b expected 101000000",
               {done0, busy0, pass0, err0, fv0, a0, b0});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({done0, pass0} !== 2'b01) begin
      tests_failed++;
      $display("FAIL and_done_pulse: got done,pass=%b expected 01", {done0, pass0});
    end
  endtask

  task automatic test_stuck_zero();
    int dc;
    gate_sel = 1;
    run_dut(0, dc);
    tests_run++;
    if (dc !== 16) begin
      tests_failed++;
      $display("FAIL stuck0_latency: got %0d expected 16", dc);
    end
    tests_run++;
    if ({pass0, err0, fv0, ffi0} !== {1'b0, 3'd1, 1'b1, 2'd3}) begin
      tests_failed++;
      $display("FAIL stuck0_result: got pass=%b err=%0d fv=%b ffi=%0d expected 0 1 1 3",
               pass0, err0, fv0, ffi0);
    end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if ({pass0, err0, fv0, ffi0} !== {1'b0, 3'd1, 1'b1, 2'd3}) begin
      tests_failed++;
      $display("FAIL stuck0_hold: got pass=%b err=%0d fv=%b ffi=%0d expected 0 1 1 3",
               pass0, err0, fv0, ffi0);
    end
  endtask

  task automatic test_nand();
    int dc;
    gate_sel = 2;
    run_dut(0, dc);
    tests_run++;
    if (dc !== 16 || {pass0, err0, fv0, ffi0} !== {1'b0, 3'd4, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL nand_result: got cyc=%0d pass=%b err=%0d fv=%b ffi=%0d expected 16 0 4 1 0",
               dc, pass0, err0, fv0, ffi0);
    end
  endtask

  task automatic test_reset_midrun();
    int dc;
    gate_sel = 0;
    repeat (2) begin @(posedge clk); #1; end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    tests_run++;
    if ({a0, b0, busy0} !== 3'b101) begin
      tests_failed++;
      $display("FAIL midrun_vector: got a,b,busy=%b expected 101", {a0, b0, busy0});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({a0, b0, busy0, done0, pass0, err0, fv0, ffi0} !== 10'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset: got %b expected 0000000000",
               {a0, b0, busy0, done0, pass0, err0, fv0, ffi0});
    end
    run_dut(0, dc);
    tests_run++;
    if (dc !== 16 || {pass0, err0, fv0} !== {1'b1, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrun_rerun: got cyc=%0d pass=%b err=%0d fv=%b expected 16 1 0 0",
               dc, pass0, err0, fv0);
    end
  endtask

  task automatic test_back_to_back();
    int first_done = -1;
    int second_done = -1;
    int n_done = 0;
    gate_sel = 0;
    repeat (2) begin @(posedge clk); #1; end
    start0 = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({busy0, pass0} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_accept: got busy,pass=%b expected 10", {busy0, pass0});
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    start0 = 1'b0;
    tests_run++;
    if (n_done !== 2 || first_done !== 16 || second_done !== 34) begin
      tests_failed++;
      $display("FAIL b2b_done: got n=%0d at %0d,%0d expected 2 at 16,34",
               n_done, first_done, second_done);
    end
    repeat (25) begin @(posedge clk); #1; end
    tests_run++;
    if ({busy0, pass0} !== 2'b01) begin
      tests_failed++;
      $display("FAIL b2b_settle: got busy,pass=%b expected 01", {busy0, pass0});
    end
  endtask

  task automatic test_xor();
    int dc;
    run_dut(1, dc);
    tests_run++;
    if (dc !== 12 || {pass1, err1, fv1} !== {1'b1, 3'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL xor_pass: got cyc=%0d pass=%b err=%0d fv=%b expected 12 1 0 0",
               dc, pass1, err1, fv1);
    end
    run_dut(2, dc);
    tests_run++;
    if (dc !== 12 || {pass2, err2, fv2, ffi2} !== {1'b0, 3'd3, 1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL xor_vs_and: got cyc=%0d pass=%b err=%0d fv=%b ffi=%0d expected 12 0 3 1 1",
               dc, pass2, err2, fv2, ffi2);
    end
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_stuck_zero();
    test_nand();
    test_reset_midrun();
    test_back_to_back();
    test_xor();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
